// File: rtl/cdb_arbiter_if.sv
// Common Data Bus arbiter bundle: functional-unit requests on one side,
// the registered CDB broadcast and grant statistics on the other.
interface cdb_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      cdb_valid;
    logic [TAG_W-1:0]          cdb_tag;
    logic [DATA_W-1:0]         cdb_data;
    logic [1:0]                cdb_src;
    logic [NUM_REQ*CNT_W-1:0]  grant_cnt;

    // Requester / observer side: drives requests, sees grants and the CDB.
    modport master (
        output req_valid, req_tag, req_data,
        input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, grant_cnt
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_tag, req_data,
        output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, grant_cnt
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the single CDB writeback slot. One functional unit
// wins per cycle; its tag/data are registered onto the CDB one cycle later.
// Saturating per-source grant counters are kept for performance analysis.
module cdb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    cdb_arbiter_if.slave bus
);
    // Two bits cover every legal requester count (2..4) and match cdb_src.
    localparam int PTR_W = 2;

    if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
        $error("cdb_arbiter: NUM_REQ must be in 2..4");
    end

    logic [PTR_W-1:0]         rr_ptr;
    logic [NUM_REQ-1:0]       grant;
    logic [PTR_W-1:0]         grant_idx;
    logic                     grant_hit;
    logic [PTR_W:0]           idx_w;
    logic [PTR_W-1:0]         search_idx;
    logic                     cdb_valid_q;
    logic [TAG_W-1:0]         cdb_tag_q;
    logic [DATA_W-1:0]        cdb_data_q;
    logic [PTR_W-1:0]         cdb_src_q;
    logic [NUM_REQ*CNT_W-1:0] cnt_q;

    // Search from rr_ptr upward (mod NUM_REQ) for the first valid requester; reset and flush suppress any grant.
    always_comb begin
        grant      = '0;
        grant_idx  = '0;
        grant_hit  = 1'b0;
        idx_w      = '0;
        search_idx = '0;
        if (!rst && !flush) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx_w = {1'b0, rr_ptr} + 3'(k);
                if (idx_w >= 3'(NUM_REQ)) begin
                    idx_w = idx_w - 3'(NUM_REQ);
                end
                search_idx = idx_w[PTR_W-1:0];
                if (!grant_hit && bus.req_valid[search_idx]) begin
                    grant_hit = 1'b1;
                    grant_idx = search_idx;
                end
            end
            if (grant_hit) begin
                grant[grant_idx] = 1'b1;
            end
        end
    end

    // Advance the round-robin pointer past the winner and register the granted slice onto the CDB.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
        end else begin
            cdb_valid_q <= grant_hit;
            if (grant_hit) begin
                cdb_tag_q  <= bus.req_tag[int'(grant_idx)*TAG_W +: TAG_W];
                cdb_data_q <= bus.req_data[int'(grant_idx)*DATA_W +: DATA_W];
                cdb_src_q  <= grant_idx;
                if (grant_idx == PTR_W'(NUM_REQ-1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= grant_idx + 2'd1;
                end
            end
        end
    end

    // Count handshakes per source, sticking at all-ones; flush leaves the counts alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_hit && grant_idx == PTR_W'(i) &&
                    cnt_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}}) begin
                    cnt_q[i*CNT_W +: CNT_W] <= cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_data  = cdb_data_q;
    assign bus.cdb_src   = cdb_src_q;
    assign bus.grant_cnt = cnt_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single source, round-robin rotation,
// idle skipping, flush behaviour and counter saturation.
module tb_cdb_arbiter;
    logic clk;
    logic rst;
    logic flush;
    int   num_checks;
    int   num_errors;

    cdb_arbiter_if #(.NUM_REQ(3), .TAG_W(4), .DATA_W(32), .CNT_W(16)) bus ();

    cdb_arbiter #(.NUM_REQ(3), .TAG_W(4), .DATA_W(32), .CNT_W(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive the control inputs and let the combinational grant settle.
    task automatic applyStimulus(input logic rst_in, input logic flush_in,
                                 input logic [2:0] valid_in);
        rst           = rst_in;
        flush         = flush_in;
        bus.req_valid = valid_in;
        #1;
    endtask

    // Advance past the next rising edge so registered outputs can be sampled.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Directed scenario sequence.
    initial begin
        num_checks   = 0;
        num_errors   = 0;
        bus.req_tag  = {4'd10, 4'd9, 4'd8};
        bus.req_data = {32'h2000_0002, 32'h2000_0001, 32'h2000_0000};
        applyStimulus(1'b1, 1'b0, 3'b111);

        // Reset held two cycles with every requester valid.
        stepClock();
        checkOutput("reset_ready", 64'(bus.req_ready), 64'h0);
        stepClock();
        checkOutput("reset_ready2", 64'(bus.req_ready), 64'h0);
        checkOutput("reset_cdb_valid", 64'(bus.cdb_valid), 64'h0);
        checkOutput("reset_cdb_tag", 64'(bus.cdb_tag), 64'h0);
        checkOutput("reset_cdb_data", 64'(bus.cdb_data), 64'h0);
        checkOutput("reset_cdb_src", 64'(bus.cdb_src), 64'h0);
        checkOutput("reset_grant_cnt", 64'(bus.grant_cnt), 64'h0);
        checkOutput("reset_rr_ptr", 64'(dut.rr_ptr), 64'h0);

        // Single source: LSQ only.
        bus.req_tag  = {4'd0, 4'd5, 4'd0};
        bus.req_data = {32'h0, 32'hDEAD_BEEF, 32'h0};
        applyStimulus(1'b0, 1'b0, 3'b010);
        checkOutput("single_ready", 64'(bus.req_ready), 64'h2);
        stepClock();
        applyStimulus(1'b0, 1'b0, 3'b000);
        checkOutput("single_cdb_valid", 64'(bus.cdb_valid), 64'h1);
        checkOutput("single_cdb_tag", 64'(bus.cdb_tag), 64'h5);
        checkOutput("single_cdb_data", 64'(bus.cdb_data), 64'hDEAD_BEEF);
        checkOutput("single_cdb_src", 64'(bus.cdb_src), 64'h1);
        checkOutput("single_cnt", 64'(bus.grant_cnt), 64'h0000_0001_0000);
        checkOutput("single_rr_ptr", 64'(dut.rr_ptr), 64'h2);
        checkOutput("idle_ready", 64'(bus.req_ready), 64'h0);

        // Reset while a new request is pending clears pointer and counters.
        applyStimulus(1'b1, 1'b0, 3'b111);
        checkOutput("rst_mid_ready", 64'(bus.req_ready), 64'h0);
        stepClock();
        checkOutput("rst_mid_cdb_valid", 64'(bus.cdb_valid), 64'h0);
        checkOutput("rst_mid_cnt", 64'(bus.grant_cnt), 64'h0);
        checkOutput("rst_mid_rr_ptr", 64'(dut.rr_ptr), 64'h0);

        // Round-robin rotation with all three requesters valid for six cycles.
        bus.req_tag  = {4'd10, 4'd9, 4'd8};
        bus.req_data = {32'h2000_0002, 32'h2000_0001, 32'h2000_0000};
        applyStimulus(1'b0, 1'b0, 3'b111);
        for (int c = 0; c < 6; c++) begin
            int g;
            g = c % 3;
            checkOutput($sformatf("rr_ready_%0d", c), 64'(bus.req_ready), 64'(1 << g));
            stepClock();
            checkOutput($sformatf("rr_src_%0d", c), 64'(bus.cdb_src), 64'(g));
            checkOutput($sformatf("rr_tag_%0d", c), 64'(bus.cdb_tag), 64'(8 + g));
            checkOutput($sformatf("rr_data_%0d", c), 64'(bus.cdb_data), 64'(32'h2000_0000 + g));
            checkOutput($sformatf("rr_valid_%0d", c), 64'(bus.cdb_valid), 64'h1);
        end
        checkOutput("rr_cnt", 64'(bus.grant_cnt), 64'h0002_0002_0002);
        checkOutput("rr_ptr_after", 64'(dut.rr_ptr), 64'h0);

        // Skip idle: move pointer to 1 via an ALU grant, then only ALU and BRA valid.
        applyStimulus(1'b0, 1'b0, 3'b001);
        checkOutput("skip_pre_ready", 64'(bus.req_ready), 64'h1);
        stepClock();
        checkOutput("skip_pre_ptr", 64'(dut.rr_ptr), 64'h1);
        applyStimulus(1'b0, 1'b0, 3'b101);
        checkOutput("skip_ready_bra", 64'(bus.req_ready), 64'h4);
        stepClock();
        checkOutput("skip_src_bra", 64'(bus.cdb_src), 64'h2);
        checkOutput("skip_ptr_wrap", 64'(dut.rr_ptr), 64'h0);
        checkOutput("skip_ready_alu", 64'(bus.req_ready), 64'h1);
        stepClock();
        checkOutput("skip_src_alu", 64'(bus.cdb_src), 64'h0);
        checkOutput("skip_cnt", 64'(bus.grant_cnt), 64'h0003_0002_0004);

        // Flush: ALU granted in cycle N, flush in N+1 with everything valid.
        applyStimulus(1'b0, 1'b0, 3'b001);
        checkOutput("flush_pre_ready", 64'(bus.req_ready), 64'h1);
        stepClock();
        applyStimulus(1'b0, 1'b1, 3'b111);
        checkOutput("flush_ready", 64'(bus.req_ready), 64'h0);
        checkOutput("flush_cdb_valid_n1", 64'(bus.cdb_valid), 64'h1);
        checkOutput("flush_cdb_src_n1", 64'(bus.cdb_src), 64'h0);
        stepClock();
        applyStimulus(1'b0, 1'b0, 3'b000);
        checkOutput("flush_cdb_valid_n2", 64'(bus.cdb_valid), 64'h0);
        checkOutput("flush_rr_ptr", 64'(dut.rr_ptr), 64'h1);
        checkOutput("flush_cnt", 64'(bus.grant_cnt), 64'h0003_0002_0005);

        // Saturation: preload BRA counter to all-ones, then grant BRA.
        force dut.cnt_q = {16'hFFFF, 16'd2, 16'd5};
        #1;
        release dut.cnt_q;
        #1;
        checkOutput("sat_preload", 64'(bus.grant_cnt), 64'hFFFF_0002_0005);
        applyStimulus(1'b0, 1'b0, 3'b100);
        checkOutput("sat_ready", 64'(bus.req_ready), 64'h4);
        stepClock();
        applyStimulus(1'b0, 1'b0, 3'b000);
        checkOutput("sat_cdb_valid", 64'(bus.cdb_valid), 64'h1);
        checkOutput("sat_cdb_src", 64'(bus.cdb_src), 64'h2);
        checkOutput("sat_cnt", 64'(bus.grant_cnt), 64'hFFFF_0002_0005);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end
endmodule
